// File: rtl/aes_sbox_arb_pkg.sv
// rtl/aes_sbox_arb_pkg.sv - shared types for the S-box word arbiter
package aes_sbox_arb_pkg;

  // Which requester owns a pipeline slot
  typedef enum logic {
    KEY = 1'b0,
    DAT = 1'b1
  } owner_t;

  // Stage 1: accepted request waiting for the substitution unit
  typedef struct packed {
    logic        valid;
    owner_t      owner;
    logic        inv;
    logic [31:0] word;
  } s1_t;

  // Stage 2: substituted word waiting for its consumer
  typedef struct packed {
    logic        valid;
    owner_t      owner;
    logic [31:0] result;
  } s2_t;

  localparam int SBOX_LATENCY = 2;

endpackage

// File: rtl/aes_sbox_word.sv
// rtl/aes_sbox_word.sv - 32-bit combinational S-box word unit (four shared-direction S-boxes)

// One byte S-box; forward and inverse share a single GF(2^8) inverter,
// only the affine pre/post maps are selected by encrypt.
module aes_sbox_canright (
  input  logic [7:0] in_byte,
  input  logic       encrypt,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre_map;
  logic [7:0] inv_val;

  // Select input map, invert once, select output map
  always_comb begin
    pre_map  = encrypt ? in_byte : inv_affine(in_byte);
    inv_val  = gf_inv(pre_map);
    out_byte = encrypt ? affine(inv_val) : inv_val;
  end

endmodule

module aes_sbox_word (
  input  logic [31:0] word,
  input  logic        encrypt,
  output logic [31:0] result
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    aes_sbox_canright u_sbox (
      .in_byte  (word[8*g +: 8]),
      .encrypt  (encrypt),
      .out_byte (result[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// rtl/aes_sbox_arbiter.sv - arbitrates key-schedule and datapath requests onto one S-box word unit
module aes_sbox_arbiter
  import aes_sbox_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        key_req_valid,
  output logic        key_req_ready,
  input  logic [31:0] key_req_word,
  output logic        key_rsp_valid,
  input  logic        key_rsp_ready,
  output logic [31:0] key_rsp_word,
  input  logic        dat_req_valid,
  output logic        dat_req_ready,
  input  logic [31:0] dat_req_word,
  input  logic        dat_req_inv,
  output logic        dat_rsp_valid,
  input  logic        dat_rsp_ready,
  output logic [31:0] dat_rsp_word,
  output logic        busy
);

  s1_t         s1_q;
  s2_t         s2_q;
  owner_t      last_grant;
  logic [31:0] sbox_result;
  logic        s2_free;
  logic        s1_free;
  logic        key_wins_tie;
  logic        key_ok;
  logic        dat_ok;
  logic        key_acc;
  logic        dat_acc;

  aes_sbox_word u_sbox_word (
    .word    (s1_q.word),
    .encrypt (~s1_q.inv),
    .result  (sbox_result)
  );

  // Pipeline advance and arbitration; readies never look at their own port's valid
  always_comb begin
    s2_free      = ~s2_q.valid | ((s2_q.owner == KEY) ? key_rsp_ready : dat_rsp_ready);
    s1_free      = ~s1_q.valid | s2_free;
    key_wins_tie = (FIXED_PRIO != 0) | (last_grant == DAT);
    key_ok       = s1_free & (~dat_req_valid | key_wins_tie);
    dat_ok       = s1_free & (~key_req_valid | ~key_wins_tie);
    key_acc      = key_req_valid & key_ok;
    dat_acc      = dat_req_valid & dat_ok;
  end

  // Ready is forced low while reset is held; accepts are ignored then anyway
  assign key_req_ready = key_ok & RST_N;
  assign dat_req_ready = dat_ok & RST_N;

  // Stage registers and round-robin history
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q       <= '0;
      s2_q       <= '0;
      last_grant <= KEY;
    end else begin
      if (s2_free) begin
        if (s1_q.valid) s2_q <= '{valid: 1'b1, owner: s1_q.owner, result: sbox_result};
        else            s2_q <= '0;
      end
      if (s1_free) begin
        if (key_acc)      s1_q <= '{valid: 1'b1, owner: KEY, inv: 1'b0, word: key_req_word};
        else if (dat_acc) s1_q <= '{valid: 1'b1, owner: DAT, inv: dat_req_inv, word: dat_req_word};
        else              s1_q <= '0;
      end
      if (key_acc)      last_grant <= KEY;
      else if (dat_acc) last_grant <= DAT;
    end
  end

  // Response steering: both channels see the S2 word, valid picks the owner
  always_comb begin
    key_rsp_valid = s2_q.valid & (s2_q.owner == KEY);
    dat_rsp_valid = s2_q.valid & (s2_q.owner == DAT);
    key_rsp_word  = s2_q.result;
    dat_rsp_word  = s2_q.result;
    busy          = s1_q.valid | s2_q.valid;
  end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb/tb_aes_sbox_arbiter.sv - self-checking bench for aes_sbox_arbiter
module tb_aes_sbox_arbiter;
  import aes_sbox_arb_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        key_req_valid;
  logic [31:0] key_req_word;
  logic        key_rsp_ready;
  logic        dat_req_valid;
  logic [31:0] dat_req_word;
  logic        dat_req_inv;
  logic        dat_rsp_ready;

  logic        key_req_ready, key_rsp_valid, dat_req_ready, dat_rsp_valid, busy;
  logic [31:0] key_rsp_word, dat_rsp_word;
  logic        p_key_req_ready, p_key_rsp_valid, p_dat_req_ready, p_dat_rsp_valid, p_busy;
  logic [31:0] p_key_rsp_word, p_dat_rsp_word;

  int checks = 0;
  int errors = 0;

  aes_sbox_arbiter #(.FIXED_PRIO(0)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .key_req_valid(key_req_valid), .key_req_ready(key_req_ready), .key_req_word(key_req_word),
    .key_rsp_valid(key_rsp_valid), .key_rsp_ready(key_rsp_ready), .key_rsp_word(key_rsp_word),
    .dat_req_valid(dat_req_valid), .dat_req_ready(dat_req_ready), .dat_req_word(dat_req_word),
    .dat_req_inv(dat_req_inv),
    .dat_rsp_valid(dat_rsp_valid), .dat_rsp_ready(dat_rsp_ready), .dat_rsp_word(dat_rsp_word),
    .busy(busy)
  );

  aes_sbox_arbiter #(.FIXED_PRIO(1)) dut_prio (
    .CLK(CLK), .RST_N(RST_N),
    .key_req_valid(key_req_valid), .key_req_ready(p_key_req_ready), .key_req_word(key_req_word),
    .key_rsp_valid(p_key_rsp_valid), .key_rsp_ready(key_rsp_ready), .key_rsp_word(p_key_rsp_word),
    .dat_req_valid(dat_req_valid), .dat_req_ready(p_dat_req_ready), .dat_req_word(dat_req_word),
    .dat_req_inv(dat_req_inv),
    .dat_rsp_valid(p_dat_rsp_valid), .dat_rsp_ready(dat_rsp_ready), .dat_rsp_word(p_dat_rsp_word),
    .busy(p_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    key_req_valid = 1'b0;
    key_req_word  = 32'h0;
    dat_req_valid = 1'b0;
    dat_req_word  = 32'h0;
    dat_req_inv   = 1'b0;
    key_rsp_ready = 1'b1;
    dat_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK);
    #3 RST_N = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic        is_dat;
    logic        inv;
    logic [31:0] word;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"key_fwd_0253",  1'b0, 1'b0, 32'h00010253, 32'h637C77ED};
    vecs[1] = '{"dat_inv_77ed",  1'b1, 1'b1, 32'h637C77ED, 32'h00010253};
    vecs[2] = '{"dat_fwd_zero",  1'b1, 1'b0, 32'h00000000, 32'h63636363};
    vecs[3] = '{"key_ign_inv",   1'b0, 1'b1, 32'h04050607, 32'hF26B6FC5};
    vecs[4] = '{"dat_fwd_0c0f",  1'b1, 1'b0, 32'h0C0D0E0F, 32'hFED7AB76};
    vecs[5] = '{"dat_inv_672b",  1'b1, 1'b1, 32'h3001672B, 32'h08090A0B};
    vecs[6] = '{"key_fwd_ff",    1'b0, 1'b0, 32'hFFFFFFFF, 32'h16161616};
    vecs[7] = '{"dat_inv_16",    1'b1, 1'b1, 32'h16161616, 32'hFFFFFFFF};

    // Reset state, with both requesters already asserting valid
    idle_inputs();
    RST_N = 1'b0;
    key_req_valid = 1'b1;
    dat_req_valid = 1'b1;
    #12;
    check("rst_key_ready", key_req_ready, 0);
    check("rst_dat_ready", dat_req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_key_rsp_valid", key_rsp_valid, 0);
    check("rst_dat_rsp_valid", dat_rsp_valid, 0);
    do_reset();
    check("rst_rsp_word", key_rsp_word, 32'h0);

    // Single transfers from the table, checking latency and channel steering
    for (int i = 0; i < 8; i++) begin
      do_reset();
      key_req_valid = ~vecs[i].is_dat;
      dat_req_valid = vecs[i].is_dat;
      key_req_word  = vecs[i].word;
      dat_req_word  = vecs[i].word;
      dat_req_inv   = vecs[i].inv;
      @(negedge CLK);
      check({vecs[i].name, "_ready"}, vecs[i].is_dat ? dat_req_ready : key_req_ready, 1);
      tick();
      key_req_valid = 1'b0;
      dat_req_valid = 1'b0;
      for (int k = 1; k <= SBOX_LATENCY; k++) begin
        @(negedge CLK);
        check({vecs[i].name, "_own_valid"}, vecs[i].is_dat ? dat_rsp_valid : key_rsp_valid,
              (k == SBOX_LATENCY) ? 1 : 0);
        check({vecs[i].name, "_other_valid"}, vecs[i].is_dat ? key_rsp_valid : dat_rsp_valid, 0);
        if (k < SBOX_LATENCY) tick();
      end
      check({vecs[i].name, "_word"}, vecs[i].is_dat ? dat_rsp_word : key_rsp_word, vecs[i].exp_word);
      tick();
      @(negedge CLK);
      check({vecs[i].name, "_drained"}, busy, 0);
    end

    // Continuous tie: round-robin alternates DAT,KEY; fixed priority keeps KEY
    do_reset();
    key_req_valid = 1'b1;
    key_req_word  = 32'h00010203;
    dat_req_valid = 1'b1;
    dat_req_word  = 32'h04050607;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      check($sformatf("rr_dat_ready_%0d", c), dat_req_ready, (c % 2 == 0) ? 1 : 0);
      check($sformatf("rr_key_ready_%0d", c), key_req_ready, (c % 2 == 1) ? 1 : 0);
      check($sformatf("fp_key_ready_%0d", c), p_key_req_ready, 1);
      check($sformatf("fp_dat_ready_%0d", c), p_dat_req_ready, 0);
      if (c >= 2) begin
        check($sformatf("rr_dat_rsp_%0d", c), dat_rsp_valid, (c % 2 == 0) ? 1 : 0);
        check($sformatf("rr_key_rsp_%0d", c), key_rsp_valid, (c % 2 == 1) ? 1 : 0);
        check($sformatf("rr_word_%0d", c), dat_rsp_word,
              (c % 2 == 0) ? 32'hF26B6FC5 : 32'h637C777B);
        check($sformatf("fp_key_rsp_%0d", c), p_key_rsp_valid, 1);
        check($sformatf("fp_word_%0d", c), p_key_rsp_word, 32'h637C777B);
      end
      tick();
    end
    key_req_valid = 1'b0;
    @(negedge CLK);
    check("fp_dat_after_key_drop", p_dat_req_ready, 1);
    tick();
    dat_req_valid = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    check("rr_idle_busy", busy, 0);
    check("fp_idle_busy", p_busy, 0);

    // DAT result stalled in S2, KEY in S1, another KEY waiting
    do_reset();
    dat_rsp_ready = 1'b0;
    dat_req_valid = 1'b1;
    dat_req_word  = 32'h00000000;
    tick();
    dat_req_valid = 1'b0;
    key_req_valid = 1'b1;
    key_req_word  = 32'h00010253;
    tick();
    key_req_word  = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check($sformatf("bp_dat_valid_%0d", c), dat_rsp_valid, 1);
      check($sformatf("bp_dat_word_%0d", c), dat_rsp_word, 32'h63636363);
      check($sformatf("bp_key_valid_%0d", c), key_rsp_valid, 0);
      check($sformatf("bp_key_ready_%0d", c), key_req_ready, 0);
      check($sformatf("bp_dat_ready_%0d", c), dat_req_ready, 0);
      tick();
    end
    dat_rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_rel_dat_valid", dat_rsp_valid, 1);
    check("bp_rel_key_ready", key_req_ready, 1);
    tick();
    key_req_valid = 1'b0;
    @(negedge CLK);
    check("bp_key1_valid", key_rsp_valid, 1);
    check("bp_key1_dat_valid", dat_rsp_valid, 0);
    check("bp_key1_word", key_rsp_word, 32'h637C77ED);
    tick();
    @(negedge CLK);
    check("bp_key2_valid", key_rsp_valid, 1);
    check("bp_key2_word", key_rsp_word, 32'h16161616);
    tick();
    @(negedge CLK);
    check("bp_end_key_valid", key_rsp_valid, 0);
    check("bp_end_busy", busy, 0);

    // Reset with both stages full discards in-flight work
    do_reset();
    dat_rsp_ready = 1'b0;
    dat_req_valid = 1'b1;
    dat_req_word  = 32'h0C0D0E0F;
    tick();
    dat_req_valid = 1'b0;
    key_req_valid = 1'b1;
    key_req_word  = 32'h00010203;
    tick();
    key_req_valid = 1'b0;
    @(negedge CLK);
    check("mr_full_busy", busy, 1);
    #2 RST_N = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_dat_valid", dat_rsp_valid, 0);
    check("mr_key_valid", key_rsp_valid, 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    dat_rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("mr_post_rsp_%0d", c), {30'b0, key_rsp_valid, dat_rsp_valid}, 0);
      check($sformatf("mr_post_busy_%0d", c), busy, 0);
      tick();
    end
    key_req_valid = 1'b1;
    dat_req_valid = 1'b1;
    @(negedge CLK);
    check("mr_tie_dat_ready", dat_req_ready, 1);
    check("mr_tie_key_ready", key_req_ready, 0);
    tick();
    @(negedge CLK);
    check("mr_tie2_key_ready", key_req_ready, 1);
    check("mr_tie2_dat_ready", dat_req_ready, 0);
    tick();
    idle_inputs();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
